// File: rtl/dsam_pkg.sv
// dsam_pkg: shared defaults, channel-index width and sign-magnitude/two's-complement helpers
// for the DSAM encoder/decoder pair. Helpers work on up to 64-bit words; w selects the width.
package dsam_pkg;
    localparam int DEFAULT_DATA_WIDTH = 16;
    localparam int DEFAULT_CHANNELS   = 2;

    function automatic int ch_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

    // Negative zero (sign set, magnitude 0) stands for -2^(w-1), the one delta sign-magnitude cannot hold.
    function automatic logic [63:0] sm_to_tc(input logic [63:0] sm, input int w);
        logic [63:0] lo;
        logic [63:0] mag;
        logic        sign;
        lo   = 64'd1 << (w - 1);
        sign = |(sm & lo);
        mag  = sm & (lo - 64'd1);
        return !sign ? mag : ((mag == '0) ? lo : -mag);
    endfunction

    function automatic logic [63:0] tc_to_sm(input logic [63:0] x, input int w);
        logic [63:0] lo;
        logic [63:0] mag;
        logic        sign;
        lo   = 64'd1 << (w - 1);
        sign = |(x & lo);
        mag  = (sign ? -x : x) & (lo - 64'd1);
        return sign ? (mag | lo) : mag;
    endfunction
endpackage

// File: rtl/dsam_decoder_if.sv
// dsam_decoder_if: encoded input stream and decoded output stream of the DSAM decoder.
interface dsam_decoder_if
    import dsam_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CHANNELS   = DEFAULT_CHANNELS
);
    localparam int CW = ch_width(CHANNELS);
    logic                  valid_in;
    logic [DATA_WIDTH-1:0] in;
    logic                  valid_out;
    logic [DATA_WIDTH-1:0] out;
    logic [CW-1:0]         channel_out;

    modport master (output valid_in, in, input valid_out, out, channel_out);
    modport slave  (input valid_in, in, output valid_out, out, channel_out);
endinterface

// File: rtl/dsam_sm_to_tc.sv
// dsam_sm_to_tc: combinational sign-magnitude to two's-complement delta conversion.
module dsam_sm_to_tc
    import dsam_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH
) (
    input  logic [DATA_WIDTH-1:0] sm_i,
    output logic [DATA_WIDTH-1:0] tc_o
);
    assign tc_o = DATA_WIDTH'(sm_to_tc(64'(sm_i), DATA_WIDTH));
endmodule

// File: rtl/dsam_decoder.sv
// dsam_decoder: rebuilds channel-interleaved samples from the DSAM word stream, one cycle latency.
// DSAM_XOR_STAGE_EN: undo the encoder's transition-XOR stage against the last accepted word.
module dsam_decoder
    import dsam_pkg::*;
#(
    parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
    parameter int CHANNELS   = DEFAULT_CHANNELS
) (
    input logic           clk,
    input logic           reset,
    dsam_decoder_if.slave bus
);
    localparam int CW = ch_width(CHANNELS);
    localparam int HN = 2 ** CW;

    logic [DATA_WIDTH-1:0] hist_q [HN];
    logic [DATA_WIDTH-1:0] out_q;
    logic [DATA_WIDTH-1:0] out_d;
    logic [DATA_WIDTH-1:0] sm;
    logic [DATA_WIDTH-1:0] delta;
    logic [CW-1:0]         ch_q;
    logic [CW-1:0]         ch_d;
    logic [CW-1:0]         chout_q;
    logic                  valid_q;

`ifdef DSAM_XOR_STAGE_EN
    logic [DATA_WIDTH-1:0] prev_q;
    assign sm = bus.in ^ prev_q;
    always_ff @(posedge clk)
        if (reset)
            prev_q <= '0;
        else if (bus.valid_in)
            prev_q <= bus.in;
`else
    assign sm = bus.in;
`endif

    dsam_sm_to_tc #(.DATA_WIDTH(DATA_WIDTH)) u_sm_to_tc (.sm_i(sm), .tc_o(delta));

    always_comb begin
        out_d = hist_q[ch_q] + delta;
        ch_d  = (ch_q == CW'(CHANNELS - 1)) ? '0 : ch_q + 1'b1;
    end

    // History is sized to a power of two so the pointer indexes it cleanly; spare entries stay zero.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < HN; i++) hist_q[i] <= '0;
            ch_q    <= '0;
            out_q   <= '0;
            chout_q <= '0;
            valid_q <= 1'b0;
        end else begin
            valid_q <= bus.valid_in;
            if (bus.valid_in) begin
                hist_q[ch_q] <= out_d;
                out_q        <= out_d;
                chout_q      <= ch_q;
                ch_q         <= ch_d;
            end
        end
    end

    assign bus.out         = out_q;
    assign bus.valid_out   = valid_q;
    assign bus.channel_out = chout_q;
endmodule

// File: tb/tb_dsam_decoder.sv
// tb_dsam_decoder: scoreboard bench for dsam_decoder with CHANNELS=2 and CHANNELS=1 instances.
module tb_dsam_decoder;
`ifdef DSAM_XOR_STAGE_EN
    localparam bit XOR_EN = 1'b1;
`else
    localparam bit XOR_EN = 1'b0;
`endif

    typedef struct {
        logic [15:0] x;
        logic        ch;
    } exp_t;

    logic clk = 1'b0;
    logic reset = 1'b1;
    int   checks = 0;
    int   errors = 0;

    exp_t        q2[$];
    logic [15:0] q1[$];

    logic [15:0] m_prev2, m_prev1, m_hist1;
    logic [15:0] m_hist2 [2];
    logic        m_ch2;

    always #5 clk = ~clk;

    dsam_decoder_if #(.DATA_WIDTH(16), .CHANNELS(2)) bus2 ();
    dsam_decoder_if #(.DATA_WIDTH(16), .CHANNELS(1)) bus1 ();

    dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(2)) dut2 (.clk(clk), .reset(reset), .bus(bus2.slave));
    dsam_decoder #(.DATA_WIDTH(16), .CHANNELS(1)) dut1 (.clk(clk), .reset(reset), .bus(bus1.slave));

    // Reference encoder: sample delta to sign-magnitude, -32768 becomes negative zero.
    function automatic logic [15:0] tc2sm(input logic [15:0] d);
        logic [15:0] n;
        n = -d;
        return d[15] ? {1'b1, n[14:0]} : d;
    endfunction

    always @(negedge clk) begin
        if (bus2.valid_out) begin
            if (q2.size() == 0) begin
                errors++;
                $display("FAIL dut2_unexpected out=%h ch=%0d required no output", bus2.out, bus2.channel_out);
            end else begin
                exp_t e;
                e = q2.pop_front();
                checks++;
                if (bus2.out !== e.x || bus2.channel_out !== e.ch) begin
                    errors++;
                    $display("FAIL dut2_word out=%h ch=%0d required out=%h ch=%0d", bus2.out, bus2.channel_out, e.x, e.ch);
                end
            end
        end
        if (bus1.valid_out) begin
            if (q1.size() == 0) begin
                errors++;
                $display("FAIL dut1_unexpected out=%h required no output", bus1.out);
            end else begin
                logic [15:0] e1;
                e1 = q1.pop_front();
                checks++;
                if (bus1.out !== e1 || bus1.channel_out !== 1'b0) begin
                    errors++;
                    $display("FAIL dut1_word out=%h ch=%0d required out=%h ch=0", bus1.out, bus1.channel_out, e1);
                end
            end
        end
    end

    task automatic idle();
        bus1.valid_in = 1'b0;
        bus2.valid_in = 1'b0;
        @(posedge clk);
        #1;
    endtask

    task automatic send(input bit one, input logic [15:0] x);
        logic [15:0] sm, e;
        if (one) begin
            sm = tc2sm(x - m_hist1);
            m_hist1 = x;
            e = XOR_EN ? (sm ^ m_prev1) : sm;
            m_prev1 = e;
            q1.push_back(x);
            bus1.in = e;
            bus1.valid_in = 1'b1;
        end else begin
            sm = tc2sm(x - m_hist2[m_ch2]);
            m_hist2[m_ch2] = x;
            e = XOR_EN ? (sm ^ m_prev2) : sm;
            m_prev2 = e;
            q2.push_back('{x: x, ch: m_ch2});
            m_ch2 = ~m_ch2;
            bus2.in = e;
            bus2.valid_in = 1'b1;
        end
        @(posedge clk);
        #1;
        bus1.valid_in = 1'b0;
        bus2.valid_in = 1'b0;
    endtask

    task automatic send_raw2(input logic [15:0] e, input logic [15:0] x, input logic ch);
        q2.push_back('{x: x, ch: ch});
        bus2.in = e;
        bus2.valid_in = 1'b1;
        @(posedge clk);
        #1;
        bus2.valid_in = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(posedge clk);
        #1;
        reset = 1'b0;
        m_prev1 = '0;
        m_prev2 = '0;
        m_hist1 = '0;
        m_hist2[0] = '0;
        m_hist2[1] = '0;
        m_ch2 = 1'b0;
    endtask

    task automatic test_reset();
        do_reset();
        do_reset();
        checks += 4;
        if (bus2.valid_out !== 1'b0 || bus2.out !== 16'h0 || bus2.channel_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut2 valid=%b out=%h ch=%0d required 0/0000/0", bus2.valid_out, bus2.out, bus2.channel_out);
        end
        if (bus1.valid_out !== 1'b0 || bus1.out !== 16'h0) begin
            errors++;
            $display("FAIL reset_dut1 valid=%b out=%h required 0/0000", bus1.valid_out, bus1.out);
        end
        if (q2.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL reset_queues q2=%0d q1=%0d required 0/0", q2.size(), q1.size());
        end
        if (bus1.channel_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_dut1_ch ch=%0d required 0", bus1.channel_out);
        end
    endtask

    task automatic test_nominal_literal();
        logic [15:0] v [8];
`ifdef DSAM_XOR_STAGE_EN
        v = '{16'h0001, 16'h0003, 16'h0001, 16'h0003, 16'h0001, 16'h0003, 16'h0001, 16'h0003};
        for (int i = 0; i < 8; i++) send_raw2(v[i], 16'(i + 1), i[0]);
`else
        v = '{16'h0001, 16'h0002, 16'h0002, 16'h0002, 16'h0, 16'h0, 16'h0, 16'h0};
        for (int i = 0; i < 4; i++) send_raw2(v[i], 16'(i + 1), i[0]);
`endif
        idle();
        checks++;
        if (q2.size() != 0) begin
            errors++;
            $display("FAIL nominal_drain pending=%0d required 0", q2.size());
        end
        do_reset();
    endtask

    task automatic test_negative_and_wrap();
        send(1'b1, 16'h0005);
        send(1'b1, 16'h0003);
        do_reset();
        send(1'b1, 16'h8000);
        send(1'b1, 16'h0000);
        do_reset();
        send(1'b1, 16'h7FFF);
        send(1'b1, 16'h8001);
        idle();
        checks++;
        if (q1.size() != 0) begin
            errors++;
            $display("FAIL wrap_drain pending=%0d required 0", q1.size());
        end
        do_reset();
    endtask

    task automatic test_bubbles();
        for (int i = 1; i <= 3; i++) send(1'b0, 16'(i));
        for (int k = 0; k < 2; k++) begin
            idle();
            checks++;
            if (bus2.valid_out !== 1'b0 || bus2.out !== 16'h0003 || bus2.channel_out !== 1'b0) begin
                errors++;
                $display("FAIL bubble_hold valid=%b out=%h ch=%0d required 0/0003/0", bus2.valid_out, bus2.out, bus2.channel_out);
            end
        end
        for (int i = 4; i <= 8; i++) send(1'b0, 16'(i));
        idle();
        do_reset();
    endtask

    task automatic test_reset_mid();
        for (int i = 1; i <= 5; i++) send(1'b0, 16'(i));
        do_reset();
        checks++;
        if (bus2.valid_out !== 1'b0 || bus2.out !== 16'h0 || bus2.channel_out !== 1'b0) begin
            errors++;
            $display("FAIL reset_mid valid=%b out=%h ch=%0d required 0/0000/0", bus2.valid_out, bus2.out, bus2.channel_out);
        end
        send(1'b0, 16'h0001);
        send(1'b0, 16'h0002);
        idle();
    endtask

    task automatic test_back_to_back_random();
        for (int i = 0; i < 60; i++) begin
            if ($urandom_range(3) == 0) idle();
            send(1'b0, 16'($urandom));
        end
        for (int i = 0; i < 30; i++) send(1'b1, 16'($urandom));
        send(1'b0, 16'h8000);
        send(1'b0, 16'h0000);
        send(1'b0, 16'h0000);
        send(1'b0, 16'h8000);
        repeat (2) idle();
        checks++;
        if (q2.size() != 0 || q1.size() != 0) begin
            errors++;
            $display("FAIL random_drain q2=%0d q1=%0d required 0/0", q2.size(), q1.size());
        end
    endtask

    initial begin
        bus1.valid_in = 1'b0;
        bus1.in = '0;
        bus2.valid_in = 1'b0;
        bus2.in = '0;
        test_reset();
        test_nominal_literal();
        test_negative_and_wrap();
        test_bubbles();
        test_reset_mid();
        test_back_to_back_random();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, errors);
        $finish;
    end
endmodule
